// File: rtl/ahb_mem_slave_pkg.sv
// ahb_mem_slave_pkg: AHB-Lite encodings and responder FSM states shared by the memory slave.
package ahb_mem_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

endpackage

// File: rtl/ahb_mem_slave_if.sv
// ahb_mem_slave_if: AHB-Lite slave-side bus bundle with master and slave views.
interface ahb_mem_slave_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_mem_slave_array.sv
// ahb_mem_slave_array: DEPTHx32 word storage, cleared on reset, one write port, async read.
module ahb_mem_slave_array #(
    parameter int DEPTH = 64
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn)
            mem_q <= '{default: '0};
        else if (we)
            mem_q[addr] <= wdata;

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite word memory responder for SINGLE/INCR4 transfers with
// per-beat wait states and two-cycle ERROR responses.
module ahb_mem_slave
    import ahb_mem_slave_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_mem_slave_if.slave   bus
);

    localparam int AW = $clog2(DEPTH) + 2;

    state_t         state_q, state_d;
    logic [AW-3:0]  addr_q, addr_d;
    logic           write_q, write_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           burst_q, burst_d;
    logic [1:0]     beats_q, beats_d;
    logic [31:0]    prev_q, prev_d;

    logic           rdy, accept, seq, idle_sel, err, we;
    logic [31:0]    rdata;

    assign rdy      = state_q inside {S_IDLE, S_DATA, S_ERR2};
    assign seq      = bus.HTRANS == HTRANS_SEQ;
    assign accept   = rdy && bus.HSEL && bus.HREADY &&
                      bus.HTRANS != HTRANS_IDLE && bus.HTRANS != HTRANS_BUSY;
    assign idle_sel = rdy && bus.HSEL && bus.HREADY && bus.HTRANS == HTRANS_IDLE;

    // A SEQ beat must continue a live INCR4 burst at exactly the next word.
    assign err = bus.HSIZE != HSIZE_WORD
              || bus.HADDR[1:0] != 2'b00
              || |bus.HADDR[31:AW]
              || !(bus.HBURST inside {HBURST_SINGLE, HBURST_INCR4})
              || (seq && (!burst_q || bus.HADDR != prev_q + 32'd4));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        beats_d = beats_q;
        prev_d  = prev_q;
        if (rdy) begin
            state_d = S_IDLE;
            if (accept) begin
                state_d = err ? S_ERR1 : (WAIT_STATES == 0 ? S_DATA : S_WAIT);
                addr_d  = bus.HADDR[AW-1:2];
                write_d = bus.HWRITE;
                prev_d  = bus.HADDR;
                cnt_d   = 2'd0;
                burst_d = bus.HTRANS == HTRANS_NONSEQ ? bus.HBURST == HBURST_INCR4
                                                      : burst_q && beats_q != 2'd2;
                beats_d = seq ? beats_q + 2'd1 : 2'd0;
            end else if (idle_sel) begin
                burst_d = 1'b0;
            end
        end else if (state_q == S_WAIT) begin
            cnt_d   = cnt_q + 2'd1;
            state_d = cnt_q == 2'(WAIT_STATES - 1) ? S_DATA : S_WAIT;
        end else begin
            state_d = S_ERR2;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= 2'd0;
            burst_q <= 1'b0;
            beats_q <= 2'd0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            beats_q <= beats_d;
            prev_q  <= prev_d;
        end

    assign we = state_q == S_DATA && write_q;

    ahb_mem_slave_array #(.DEPTH(DEPTH)) u_array (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .we      (we),
        .addr    (addr_q),
        .wdata   (bus.HWDATA),
        .rdata   (rdata)
    );

    assign bus.HREADYOUT = !(state_q inside {S_WAIT, S_ERR1});
    assign bus.HRESP     = state_q inside {S_ERR1, S_ERR2} ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = state_q == S_DATA && !write_q ? rdata : '0;

endmodule
